ft_tx_arbiter: RTL
==================

// Module: ft_tx_arbiter
// PURPOSE
//  Shares the single FT245 transmit byte path between three sources: CCD pixel FIFO (bulk),
//  MCP3008 temperature word (10 bit), and one-byte command responses. Wraps each transfer in a
//  tagged frame so the host can demultiplex. Sits between ccd/fifo/mcp logic and sync_ft245.
// PARAMETERS
//  CCD_BURST  64  payload bytes per full CCD frame (1..64)
//  LVL_W      9   width of ccd_level (FIFO fill count)
// PORTS
//  clk         in   1      system clock; all logic on posedge
//  rst         in   1      asynchronous, active-high reset
//  ccd_data    in   8      FIFO head byte (show-ahead)
//  ccd_valid   in   1      FIFO not empty
//  ccd_level   in   LVL_W  bytes currently in FIFO
//  ccd_flush   in   1      level pulse: send remaining (<CCD_BURST) bytes as short frame
//  ccd_ready   out  1      FIFO pop; high exactly on each CCD payload handshake
//  mcp_req     in   1      new temperature word pending (held until ack)
//  mcp_word    in   10     temperature sample
//  mcp_ack     out  1      1-cycle pulse when word latched
//  rsp_req     in   1      response byte pending (held until ack)
//  rsp_byte    in   8      response byte
//  rsp_ack     out  1      1-cycle pulse when byte latched
//  tx_data     out  8      byte to sync_ft245
//  tx_valid    out  1      tx_data valid
//  tx_ready    in   1      sync_ft245 accepts byte this cycle
//  grant       out  2      current owner: 0 none, 1 mcp, 2 rsp, 3 ccd
//  busy        out  1      frame in progress
// BEHAVIOUR
//  - Reset: state IDLE; tx_valid=0, tx_data=0, ccd_ready=0, mcp_ack=0, rsp_ack=0, grant=0,
//    busy=0; flush_pend cleared. Reset mid-frame aborts the frame (host resyncs on tags).
//  - Handshake: byte moves when tx_valid&&tx_ready. tx_data stable while tx_valid&&!tx_ready.
//  - Header byte = {tag[1:0], len_m1[5:0]}; tags MCP=2'b01, RSP=2'b10, CCD=2'b11.
//  - FSM: IDLE -> HDR -> {MCP_MSB->MCP_LSB | RSP_BYTE | CCD_DATA} -> IDLE.
//  - IDLE arbitration, fixed priority rsp > mcp > ccd, evaluated every cycle in IDLE:
//      rsp_req -> latch rsp_byte, rsp_ack pulse, header 8'h80.
//      mcp_req -> latch mcp_word, mcp_ack pulse, header 8'h41.
//      ccd_level>=CCD_BURST -> len=CCD_BURST; else flush_pend&&ccd_level!=0 -> len=ccd_level.
//    Grant registered: header presented with tx_valid=1 on the cycle after the grant decision.
//  - Non-preemptive: a frame completes before re-arbitration; at least 1 IDLE cycle between frames.
//  - MCP payload: {6'b0, word[9:8]} then word[7:0].
//  - CCD_DATA: tx_data=ccd_data, tx_valid=ccd_valid, ccd_ready=tx_ready&&ccd_valid (comb.);
//    byte counter decrements per handshake; exit at 0. ccd_valid low mid-frame -> stall.
//  - ccd_flush sets flush_pend; cleared when a short frame is granted or when ccd_level==0 in IDLE.
//    Flush with level>=CCD_BURST: full frames first, short frame for remainder.
//  - Requests raised in same cycle: priority order; losers stay pending (req held by source).
//  - grant/busy registered; busy=1 from HDR through last payload handshake.
// CONFIGURATION
//  FT_TX_CHECKSUM_EN defined: extra trailer state CSUM after payload sends XOR of header and all
//    payload bytes; frame length +1. Undefined: no trailer, CSUM state absent.
// STRUCTURE
//  ft_tx_arbiter.vh: tag localparams, header constants, Gray-coded state localparams, grant codes.
//  Sub-module ft_tx_checksum (running XOR, clear/accumulate), instantiated only under macro.
// TESTING
//  1. rsp_req=1, rsp_byte=8'h5A, tx_ready=1 -> tx stream 80,5A; rsp_ack one pulse; busy drops.
//  2. mcp_word=10'h2C7 -> 41,02,C7; tx_ready held low 5 cycles on byte 2 -> byte stays 02.
//  3. ccd_level=64, bytes 00..3F -> header FF then 00..3F; exactly 64 ccd_ready pulses.
//  4. ccd_level=5, ccd_flush pulse -> C4 then 5 bytes; flush_pend clear; no further frame.
//  5. rsp_req, mcp_req and ccd full all same cycle -> frame order rsp, mcp, ccd, no interleave.
//  6. rst asserted mid CCD frame -> all outputs 0 next edge; with FT_TX_CHECKSUM_EN, test 1
//     yields 80,5A,DA.

Source files
------------

// File: rtl/ft_tx_arbiter_pkg.sv
// Shared constants for the FT245 transmit arbiter: frame tags, fixed headers,
// grant codes and the Gray-coded state set (CSUM exists only with FT_TX_CHECKSUM_EN).
package ft_tx_arbiter_pkg;

    localparam logic [1:0] TAG_MCP = 2'b01;
    localparam logic [1:0] TAG_RSP = 2'b10;
    localparam logic [1:0] TAG_CCD = 2'b11;

    localparam logic [7:0] HDR_RSP = {TAG_RSP, 6'd0};
    localparam logic [7:0] HDR_MCP = {TAG_MCP, 6'd1};

    localparam logic [1:0] GNT_NONE = 2'd0;
    localparam logic [1:0] GNT_MCP  = 2'd1;
    localparam logic [1:0] GNT_RSP  = 2'd2;
    localparam logic [1:0] GNT_CCD  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE     = 3'b000,
        S_HDR      = 3'b001,
        S_MCP_MSB  = 3'b011,
        S_MCP_LSB  = 3'b010,
        S_RSP_BYTE = 3'b110,
        S_CCD_DATA = 3'b111
`ifdef FT_TX_CHECKSUM_EN
        ,
        S_CSUM     = 3'b101
`endif
    } state_e;

    function automatic logic [7:0] mk_hdr(input logic [1:0] tag,
                                          input logic [6:0] len);
        return {tag, 6'(len - 7'd1)};
    endfunction

endpackage

// File: rtl/ft_tx_checksum.sv
// Running XOR over every byte of a frame; cleared between frames.
// Built only when FT_TX_CHECKSUM_EN is defined.
`ifdef FT_TX_CHECKSUM_EN
module ft_tx_checksum (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       acc,
    input  logic [7:0] din,
    output logic [7:0] sum
);

    logic [7:0] sum_q, sum_d;

    // clear wins over accumulate so a new frame starts from zero
    always_comb begin
        sum_d = sum_q;
        if (clr)
            sum_d = 8'h00;
        else if (acc)
            sum_d = sum_q ^ din;
    end

    // running XOR register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sum_q <= 8'h00;
        else
            sum_q <= sum_d;
    end

    assign sum = sum_q;

endmodule
`endif

// File: rtl/ft_tx_arbiter.sv
// Arbitrates rsp > mcp > ccd onto one FT245 byte stream as tagged frames.
// Define FT_TX_CHECKSUM_EN to append an XOR trailer byte to every frame.
module ft_tx_arbiter
    import ft_tx_arbiter_pkg::*;
#(
    parameter int CCD_BURST = 64,
    parameter int LVL_W     = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       ccd_data,
    input  logic             ccd_valid,
    input  logic [LVL_W-1:0] ccd_level,
    input  logic             ccd_flush,
    output logic             ccd_ready,
    input  logic             mcp_req,
    input  logic [9:0]       mcp_word,
    output logic             mcp_ack,
    input  logic             rsp_req,
    input  logic [7:0]       rsp_byte,
    output logic             rsp_ack,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic [1:0]       grant,
    output logic             busy
);

    localparam logic [6:0] BURST = 7'(CCD_BURST);

    state_e     state_q, state_d;
    logic [7:0] hdr_q, hdr_d;
    logic [7:0] lsb_q, lsb_d;
    logic [1:0] msb_q, msb_d;
    logic [6:0] cnt_q, cnt_d;
    logic [1:0] grant_q, grant_d;
    logic       busy_q, busy_d;
    logic       flush_q, flush_d;
    logic       mcp_ack_q, mcp_ack_d;
    logic       rsp_ack_q, rsp_ack_d;
    logic       last;
    logic       ccd_full;
    logic       ccd_empty;
    logic [6:0] short_len;

    assign ccd_full  = ccd_level >= LVL_W'(CCD_BURST);
    assign ccd_empty = ccd_level == '0;
    assign short_len = 7'(ccd_level);

`ifdef FT_TX_CHECKSUM_EN
    logic [7:0] csum;

    ft_tx_checksum u_csum (
        .clk (clk),
        .rst (rst),
        .clr (state_q == S_IDLE),
        .acc (tx_valid && tx_ready && state_q != S_CSUM),
        .din (tx_data),
        .sum (csum)
    );
`endif

    // next-state, arbitration and byte-path muxing
    always_comb begin
        state_d   = state_q;
        hdr_d     = hdr_q;
        lsb_d     = lsb_q;
        msb_d     = msb_q;
        cnt_d     = cnt_q;
        grant_d   = grant_q;
        busy_d    = busy_q;
        flush_d   = flush_q;
        mcp_ack_d = 1'b0;
        rsp_ack_d = 1'b0;
        last      = 1'b0;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        ccd_ready = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ccd_empty)
                    flush_d = 1'b0;
                if (rsp_req) begin
                    state_d   = S_HDR;
                    hdr_d     = HDR_RSP;
                    lsb_d     = rsp_byte;
                    rsp_ack_d = 1'b1;
                    grant_d   = GNT_RSP;
                    busy_d    = 1'b1;
                end else if (mcp_req) begin
                    state_d   = S_HDR;
                    hdr_d     = HDR_MCP;
                    lsb_d     = mcp_word[7:0];
                    msb_d     = mcp_word[9:8];
                    mcp_ack_d = 1'b1;
                    grant_d   = GNT_MCP;
                    busy_d    = 1'b1;
                end else if (ccd_full) begin
                    state_d = S_HDR;
                    hdr_d   = mk_hdr(TAG_CCD, BURST);
                    cnt_d   = BURST;
                    grant_d = GNT_CCD;
                    busy_d  = 1'b1;
                end else if (flush_q && !ccd_empty) begin
                    state_d = S_HDR;
                    hdr_d   = mk_hdr(TAG_CCD, short_len);
                    cnt_d   = short_len;
                    flush_d = 1'b0;
                    grant_d = GNT_CCD;
                    busy_d  = 1'b1;
                end
            end
            S_HDR: begin
                tx_valid = 1'b1;
                tx_data  = hdr_q;
                if (tx_ready) begin
                    case (grant_q)
                        GNT_MCP: state_d = S_MCP_MSB;
                        GNT_RSP: state_d = S_RSP_BYTE;
                        default: state_d = S_CCD_DATA;
                    endcase
                end
            end
            S_MCP_MSB: begin
                tx_valid = 1'b1;
                tx_data  = {6'b0, msb_q};
                if (tx_ready)
                    state_d = S_MCP_LSB;
            end
            S_MCP_LSB, S_RSP_BYTE: begin
                tx_valid = 1'b1;
                tx_data  = lsb_q;
                last     = tx_ready;
            end
            S_CCD_DATA: begin
                tx_valid  = ccd_valid;
                tx_data   = ccd_data;
                ccd_ready = tx_ready && ccd_valid;
                if (ccd_ready) begin
                    cnt_d = cnt_q - 7'd1;
                    last  = cnt_q == 7'd1;
                end
            end
`ifdef FT_TX_CHECKSUM_EN
            S_CSUM: begin
                tx_valid = 1'b1;
                tx_data  = csum;
                if (tx_ready) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    grant_d = GNT_NONE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        if (last) begin
`ifdef FT_TX_CHECKSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_IDLE;
            busy_d  = 1'b0;
            grant_d = GNT_NONE;
`endif
        end

        if (ccd_flush)
            flush_d = 1'b1;
    end

    // state and frame context registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            hdr_q     <= 8'h00;
            lsb_q     <= 8'h00;
            msb_q     <= 2'b00;
            cnt_q     <= 7'd0;
            grant_q   <= GNT_NONE;
            busy_q    <= 1'b0;
            flush_q   <= 1'b0;
            mcp_ack_q <= 1'b0;
            rsp_ack_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hdr_q     <= hdr_d;
            lsb_q     <= lsb_d;
            msb_q     <= msb_d;
            cnt_q     <= cnt_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
            flush_q   <= flush_d;
            mcp_ack_q <= mcp_ack_d;
            rsp_ack_q <= rsp_ack_d;
        end
    end

    assign grant   = grant_q;
    assign busy    = busy_q;
    assign mcp_ack = mcp_ack_q;
    assign rsp_ack = rsp_ack_q;

endmodule
